// File: rtl/rx_uart_lite_pkg.sv
// rtl/rx_uart_lite_pkg.sv - shared constants, state encoding and load helper for rx_uart_lite
package rx_uart_lite_pkg;

  // Baud counter width; CLOCKS_PER_BAUD must fit in it
  localparam int unsigned CNT_W = 24;

  // 100 MHz system clock at 115200 baud
  localparam logic [CNT_W-1:0] CLOCKS_PER_BAUD_DEF = 24'd868;

  // Receiver FSM encoding
  typedef logic [1:0] rx_state_t;
  localparam rx_state_t ST_IDLE  = 2'd0;
  localparam rx_state_t ST_START = 2'd1;
  localparam rx_state_t ST_DATA  = 2'd2;
  localparam rx_state_t ST_STOP  = 2'd3;

  // Counter load that lands the first expiry in the middle of the start bit
  function automatic logic [CNT_W-1:0] half_bit_load(input logic [CNT_W-1:0] cpb);
    return (cpb >> 1) - CNT_W'(1);
  endfunction

endpackage

// File: rtl/rx_uart_lite_sync.sv
// rtl/rx_uart_lite_sync.sv - two-flop synchronizer, edge-detect flop and line-high arming for the RX pin
module rx_uart_lite_sync (
  input  logic i_clk,
  input  logic i_reset,
  input  logic i_rx,
  output logic o_rx_s,
  output logic o_rx_fall
);

  logic       rx_m;
  logic       rx_s;
  logic       rx_d;
  logic [1:0] fill;
  logic       armed;

  // Synchronize the raw line and keep one delayed copy; all flops idle high
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      rx_m <= 1'b1;
      rx_s <= 1'b1;
      rx_d <= 1'b1;
    end else begin
      rx_m <= i_rx;
      rx_s <= rx_m;
      rx_d <= rx_s;
    end
  end

  // The reset-to-1 values are not real line samples, so only arm edge
  // detection after rx_s has carried a genuine high from the pin
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      fill  <= 2'b00;
      armed <= 1'b0;
    end else begin
      fill <= {fill[0], 1'b1};
      if (fill[1] && rx_s) begin
        armed <= 1'b1;
      end
    end
  end

  assign o_rx_s    = rx_s;
  assign o_rx_fall = armed & rx_d & ~rx_s;

endmodule

// File: rtl/rx_uart_lite.sv
// rtl/rx_uart_lite.sv - 8N1 UART receiver; define RX_UART_LITE_FRAME_ERR_EN for stop-bit checking and o_frame_err
module rx_uart_lite
  import rx_uart_lite_pkg::*;
#(
  parameter logic [CNT_W-1:0] CLOCKS_PER_BAUD = CLOCKS_PER_BAUD_DEF
) (
  input  logic       i_clk,
  input  logic       i_reset,
  input  logic       i_uart_rx,
  output logic       o_wr,
`ifdef RX_UART_LITE_FRAME_ERR_EN
  output logic [7:0] o_data,
  output logic       o_frame_err
`else
  output logic [7:0] o_data
`endif
);

  localparam logic [CNT_W-1:0] HALF_LOAD = half_bit_load(CLOCKS_PER_BAUD);
  localparam logic [CNT_W-1:0] FULL_LOAD = CLOCKS_PER_BAUD - CNT_W'(1);

  logic             rx_s;
  logic             rx_fall;
  rx_state_t        state;
  rx_state_t        state_nxt;
  logic [CNT_W-1:0] cnt;
  logic [2:0]       bit_idx;
  logic [7:0]       shreg;
  logic             baud_tick;
  logic             stop_tick;
  logic             stop_good;

  rx_uart_lite_sync u_sync (
    .i_clk     (i_clk),
    .i_reset   (i_reset),
    .i_rx      (i_uart_rx),
    .o_rx_s    (rx_s),
    .o_rx_fall (rx_fall)
  );

  assign baud_tick = (cnt == '0);
  assign stop_tick = (state == ST_STOP) && baud_tick;

`ifdef RX_UART_LITE_FRAME_ERR_EN
  assign stop_good = rx_s;
`else
  assign stop_good = 1'b1;
`endif

  // Next state: frame sequencing driven by the baud counter expiring
  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE:  if (rx_fall) state_nxt = ST_START;
      ST_START: if (baud_tick) state_nxt = rx_s ? ST_IDLE : ST_DATA;
      ST_DATA:  if (baud_tick && (bit_idx == 3'd7)) state_nxt = ST_STOP;
      ST_STOP:  if (baud_tick) state_nxt = ST_IDLE;
      default:  state_nxt = ST_IDLE;
    endcase
  end

  // State register; STOP returns to IDLE at mid stop bit so a back-to-back start edge is seen
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Baud counter: half-bit load on the start edge, full-bit reload at every expiry
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      cnt <= '0;
    end else if (state == ST_IDLE) begin
      if (rx_fall) begin
        cnt <= HALF_LOAD;
      end
    end else if (baud_tick) begin
      cnt <= FULL_LOAD;
    end else begin
      cnt <= cnt - CNT_W'(1);
    end
  end

  // Data capture: LSB arrives first, so shift right and insert at the MSB
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      bit_idx <= 3'd0;
      shreg   <= 8'h00;
    end else if ((state == ST_START) && baud_tick) begin
      bit_idx <= 3'd0;
    end else if ((state == ST_DATA) && baud_tick) begin
      shreg   <= {rx_s, shreg[7:1]};
      bit_idx <= bit_idx + 3'd1;
    end
  end

  // Byte delivery: one-cycle strobe after the stop sample, o_data moves only with it
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      o_wr   <= 1'b0;
      o_data <= 8'h00;
    end else begin
      o_wr <= stop_tick & stop_good;
      if (stop_tick && stop_good) begin
        o_data <= shreg;
      end
    end
  end

`ifdef RX_UART_LITE_FRAME_ERR_EN
  // Framing error pulse on a low stop sample; IDLE re-arms only after a fresh falling edge
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      o_frame_err <= 1'b0;
    end else begin
      o_frame_err <= stop_tick & ~rx_s;
    end
  end
`endif

endmodule

// File: tb/tb_rx_uart_lite.sv
// tb/tb_rx_uart_lite.sv - self-checking bench for rx_uart_lite with a timing/data reference model
module tb_rx_uart_lite;

  localparam int CPB = 16;

  logic       clk = 1'b0;
  logic       rst;
  logic       rx;
  logic       wr;
  logic [7:0] data;
`ifdef RX_UART_LITE_FRAME_ERR_EN
  logic       ferr;
`endif

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;

  int         wr_cyc_q[$];
  logic [7:0] wr_dat_q[$];
  int         fe_cyc_q[$];
  int         data_moved = 0;
  logic [7:0] prev_data;
  logic [7:0] last_byte;

  rx_uart_lite #(.CLOCKS_PER_BAUD(24'd16)) dut (
    .i_clk      (clk),
    .i_reset    (rst),
    .i_uart_rx  (rx),
    .o_wr       (wr),
`ifdef RX_UART_LITE_FRAME_ERR_EN
    .o_data     (data),
    .o_frame_err(ferr)
`else
    .o_data     (data)
`endif
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Record every strobe with the cycle it was seen in, and any o_data change without a strobe
  always @(negedge clk) begin
    if (wr === 1'b1) begin
      wr_cyc_q.push_back(cyc);
      wr_dat_q.push_back(data);
    end
    if (!rst && (wr !== 1'b1) && (data !== prev_data)) data_moved <= data_moved + 1;
    prev_data <= data;
`ifdef RX_UART_LITE_FRAME_ERR_EN
    if (ferr === 1'b1) fe_cyc_q.push_back(cyc);
`endif
  end

  // Model: line falls just after cycle n, first sync flop sees it at t0=n+1,
  // strobe is visible in cycle t0 + 2 + CPB/2 + 9*CPB
  function automatic int exp_strobe(input int n);
    return n + 1 + 2 + CPB / 2 + 9 * CPB;
  endfunction

  task automatic drive_bit(input logic v);
    rx = v;
    repeat (CPB) @(posedge clk);
    #1;
  endtask

  task automatic idle(input int k);
    rx = 1'b1;
    repeat (k) @(posedge clk);
    #1;
  endtask

  task automatic send_frame(input logic [7:0] b, input logic stop, output int n);
    n = cyc;
    drive_bit(1'b0);
    for (int k = 0; k < 8; k++) drive_bit(b[k]);
    drive_bit(stop);
    rx = 1'b1;
  endtask

  task automatic clear_mon();
    wr_cyc_q.delete();
    wr_dat_q.delete();
    fe_cyc_q.delete();
  endtask

  task automatic test_reset();
    rst = 1'b1;
    rx  = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    n_checks++; if (wr !== 1'b0) begin n_fail++; $display("FAIL reset_wr: got %b expected 0", wr); end
    n_checks++; if (data !== 8'h00) begin n_fail++; $display("FAIL reset_data: got %h expected 00", data); end
`ifdef RX_UART_LITE_FRAME_ERR_EN
    n_checks++; if (ferr !== 1'b0) begin n_fail++; $display("FAIL reset_ferr: got %b expected 0", ferr); end
`endif
    rst = 1'b0;
    idle(10);
    last_byte = 8'h00;
  endtask

  task automatic test_basic();
    int n;
    clear_mon();
    send_frame(8'h55, 1'b1, n);
    idle(20);
    n_checks++;
    if (wr_cyc_q.size() != 1) begin
      n_fail++; $display("FAIL basic_count: got %0d strobes expected 1", wr_cyc_q.size());
    end else begin
      n_checks++; if (wr_cyc_q[0] != exp_strobe(n)) begin n_fail++; $display("FAIL basic_time: got cycle %0d expected %0d", wr_cyc_q[0], exp_strobe(n)); end
      n_checks++; if (wr_dat_q[0] !== 8'h55) begin n_fail++; $display("FAIL basic_data: got %h expected 55", wr_dat_q[0]); end
    end
    n_checks++; if (data !== 8'h55) begin n_fail++; $display("FAIL basic_hold: got %h expected 55", data); end
    last_byte = 8'h55;
  endtask

  task automatic test_back_to_back();
    int n0, n1;
    clear_mon();
    send_frame(8'hA5, 1'b1, n0);
    send_frame(8'h3C, 1'b1, n1);
    idle(20);
    n_checks++;
    if (wr_cyc_q.size() != 2) begin
      n_fail++; $display("FAIL b2b_count: got %0d strobes expected 2", wr_cyc_q.size());
    end else begin
      n_checks++; if (wr_cyc_q[0] != exp_strobe(n0)) begin n_fail++; $display("FAIL b2b_time0: got %0d expected %0d", wr_cyc_q[0], exp_strobe(n0)); end
      n_checks++; if (wr_cyc_q[1] - wr_cyc_q[0] != 10 * CPB) begin n_fail++; $display("FAIL b2b_spacing: got %0d expected %0d", wr_cyc_q[1] - wr_cyc_q[0], 10 * CPB); end
      n_checks++; if (wr_dat_q[0] !== 8'hA5) begin n_fail++; $display("FAIL b2b_data0: got %h expected a5", wr_dat_q[0]); end
      n_checks++; if (wr_dat_q[1] !== 8'h3C) begin n_fail++; $display("FAIL b2b_data1: got %h expected 3c", wr_dat_q[1]); end
    end
    last_byte = 8'h3C;
  endtask

  task automatic test_glitch();
    int n;
    clear_mon();
    rx = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    idle(40);
    n_checks++; if (wr_cyc_q.size() != 0) begin n_fail++; $display("FAIL glitch_strobe: got %0d strobes expected 0", wr_cyc_q.size()); end
    send_frame(8'h81, 1'b1, n);
    idle(20);
    n_checks++;
    if (wr_cyc_q.size() != 1) begin
      n_fail++; $display("FAIL glitch_next_count: got %0d strobes expected 1", wr_cyc_q.size());
    end else begin
      n_checks++; if (wr_cyc_q[0] != exp_strobe(n)) begin n_fail++; $display("FAIL glitch_next_time: got %0d expected %0d", wr_cyc_q[0], exp_strobe(n)); end
      n_checks++; if (wr_dat_q[0] !== 8'h81) begin n_fail++; $display("FAIL glitch_next_data: got %h expected 81", wr_dat_q[0]); end
    end
    last_byte = 8'h81;
  endtask

  task automatic test_frame_err();
    int n;
    clear_mon();
    send_frame(8'hF0, 1'b0, n);
    idle(20);
`ifdef RX_UART_LITE_FRAME_ERR_EN
    n_checks++; if (wr_cyc_q.size() != 0) begin n_fail++; $display("FAIL ferr_strobe: got %0d strobes expected 0", wr_cyc_q.size()); end
    n_checks++;
    if (fe_cyc_q.size() != 1) begin
      n_fail++; $display("FAIL ferr_count: got %0d pulses expected 1", fe_cyc_q.size());
    end else begin
      n_checks++; if (fe_cyc_q[0] != exp_strobe(n)) begin n_fail++; $display("FAIL ferr_time: got %0d expected %0d", fe_cyc_q[0], exp_strobe(n)); end
    end
    n_checks++; if (data !== last_byte) begin n_fail++; $display("FAIL ferr_data_hold: got %h expected %h", data, last_byte); end
`else
    n_checks++;
    if (wr_cyc_q.size() != 1) begin
      n_fail++; $display("FAIL badstop_count: got %0d strobes expected 1", wr_cyc_q.size());
    end else begin
      n_checks++; if (wr_cyc_q[0] != exp_strobe(n)) begin n_fail++; $display("FAIL badstop_time: got %0d expected %0d", wr_cyc_q[0], exp_strobe(n)); end
      n_checks++; if (wr_dat_q[0] !== 8'hF0) begin n_fail++; $display("FAIL badstop_data: got %h expected f0", wr_dat_q[0]); end
    end
    last_byte = 8'hF0;
`endif
  endtask

  task automatic test_reset_mid_byte();
    int n;
    logic [7:0] b;
    b = 8'hB6;
    clear_mon();
    drive_bit(1'b0);
    for (int k = 0; k < 4; k++) drive_bit(b[k]);
    rst = 1'b1;
    rx  = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    n_checks++; if (data !== 8'h00) begin n_fail++; $display("FAIL midrst_data: got %h expected 00", data); end
    n_checks++; if (wr !== 1'b0) begin n_fail++; $display("FAIL midrst_wr: got %b expected 0", wr); end
    rst = 1'b0;
    idle(200);
    n_checks++; if (wr_cyc_q.size() != 0) begin n_fail++; $display("FAIL midrst_strobe: got %0d strobes expected 0", wr_cyc_q.size()); end
    send_frame(8'h3C, 1'b1, n);
    idle(20);
    n_checks++;
    if (wr_cyc_q.size() != 1) begin
      n_fail++; $display("FAIL midrst_next_count: got %0d strobes expected 1", wr_cyc_q.size());
    end else begin
      n_checks++; if (wr_cyc_q[0] != exp_strobe(n)) begin n_fail++; $display("FAIL midrst_next_time: got %0d expected %0d", wr_cyc_q[0], exp_strobe(n)); end
      n_checks++; if (wr_dat_q[0] !== 8'h3C) begin n_fail++; $display("FAIL midrst_next_data: got %h expected 3c", wr_dat_q[0]); end
    end
    last_byte = 8'h3C;
  endtask

  task automatic test_low_through_reset();
    int n;
    clear_mon();
    rx  = 1'b0;
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    repeat (200) @(posedge clk);
    #1;
    n_checks++; if (wr_cyc_q.size() != 0) begin n_fail++; $display("FAIL lowrst_strobe: got %0d strobes expected 0", wr_cyc_q.size()); end
    n_checks++; if (fe_cyc_q.size() != 0) begin n_fail++; $display("FAIL lowrst_ferr: got %0d pulses expected 0", fe_cyc_q.size()); end
    n_checks++; if (data !== 8'h00) begin n_fail++; $display("FAIL lowrst_data: got %h expected 00", data); end
    idle(20);
    send_frame(8'hC3, 1'b1, n);
    idle(20);
    n_checks++;
    if (wr_cyc_q.size() != 1) begin
      n_fail++; $display("FAIL lowrst_next_count: got %0d strobes expected 1", wr_cyc_q.size());
    end else begin
      n_checks++; if (wr_cyc_q[0] != exp_strobe(n)) begin n_fail++; $display("FAIL lowrst_next_time: got %0d expected %0d", wr_cyc_q[0], exp_strobe(n)); end
      n_checks++; if (wr_dat_q[0] !== 8'hC3) begin n_fail++; $display("FAIL lowrst_next_data: got %h expected c3", wr_dat_q[0]); end
    end
    last_byte = 8'hC3;
  endtask

  task automatic test_random();
    int         exp_cyc[$];
    logic [7:0] exp_dat[$];
    int         n;
    int         gap;
    logic [7:0] b;
    clear_mon();
    for (int i = 0; i < 10; i++) begin
      b   = 8'($urandom_range(0, 255));
      gap = ($urandom_range(0, 2) == 0) ? 0 : int'($urandom_range(1, 30));
      if (gap > 0) idle(gap);
      send_frame(b, 1'b1, n);
      exp_cyc.push_back(exp_strobe(n));
      exp_dat.push_back(b);
    end
    idle(20);
    n_checks++;
    if (wr_cyc_q.size() != exp_cyc.size()) begin
      n_fail++; $display("FAIL rand_count: got %0d strobes expected %0d", wr_cyc_q.size(), exp_cyc.size());
    end else begin
      for (int i = 0; i < exp_cyc.size(); i++) begin
        n_checks++; if (wr_cyc_q[i] != exp_cyc[i]) begin n_fail++; $display("FAIL rand_time[%0d]: got %0d expected %0d", i, wr_cyc_q[i], exp_cyc[i]); end
        n_checks++; if (wr_dat_q[i] !== exp_dat[i]) begin n_fail++; $display("FAIL rand_data[%0d]: got %h expected %h", i, wr_dat_q[i], exp_dat[i]); end
      end
      last_byte = exp_dat[exp_dat.size() - 1];
    end
    n_checks++; if (data !== last_byte) begin n_fail++; $display("FAIL rand_hold: got %h expected %h", data, last_byte); end
  endtask

  task automatic test_data_hold();
    n_checks++;
    if (data_moved != 0) begin n_fail++; $display("FAIL data_hold: o_data changed %0d times without o_wr, expected 0", data_moved); end
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1);
  end

  initial begin
    rst = 1'b1;
    rx  = 1'b1;
    test_reset();
    test_basic();
    test_back_to_back();
    test_glitch();
    test_frame_err();
    test_reset_mid_byte();
    test_low_through_reset();
    test_random();
    test_data_hold();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
